// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
// Request sizes, controller states and the store byte-enable decode.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Lane 0 is bits [7:0]; a reserved size yields no enables.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = 4'b0011 << lane;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load-path lane select and sign/zero extension of a 32-bit little-endian word.
// Purely combinational; the caller registers the result.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] rdata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        sel_half = 16'h0000;
        rdata    = 32'h0000_0000;
        case (lane)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: rdata = zero_ext ? {24'h0, sel_byte}
                                        : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: rdata = zero_ext ? {16'h0, sel_half}
                                        : {{16{sel_half[15]}}, sel_half};
            SIZE_WORD: rdata = word;
            default:   rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// Byte-addressable little-endian data memory with valid/ready requests,
// a registered one-cycle response and optional zero-fill after reset.
//
//  state | meaning
//  CLEAR | walking the array writing zeros, one word per cycle; not ready
//  READY | accepting one request per cycle
module data_ram
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int INIT_CLEAR  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    ram_state_t state, state_nxt;
    logic [IDX_W-1:0] clr_cnt;

    logic [IDX_W-1:0]      word_idx;
    logic [ADDR_WIDTH-1:0] word_num;
    logic [1:0]            lane;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_err;
    logic                  accept;
    logic                  do_store;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_rep;
    logic [31:0]           load_word;
    logic [31:0]           load_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= (INIT_CLEAR != 0) ? CLEAR : READY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_nxt = READY;
                end
            end
            READY: req_ready = 1'b1;
            default: state_nxt = READY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Range check uses the full address so high addresses never alias low words.
    assign word_num     = req_address >> 2;
    assign word_idx     = req_address[IDX_W+1:2];
    assign lane         = req_address[1:0];
    assign out_of_range = (word_num >= ADDR_WIDTH'(DEPTH_WORDS));

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = lane[0];
            SIZE_WORD: misaligned = (lane != 2'd0);
            default:   misaligned = 1'b1;
        endcase
    end

    assign req_err  = misaligned | out_of_range;
    assign accept   = req_valid & req_ready & ~reset;
    assign do_store = accept & req_write & ~req_err;
    assign byte_en  = byte_enables(req_size, lane);

    always_comb begin
        wdata_rep = req_wdata;
        case (req_size)
            SIZE_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SIZE_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default:   wdata_rep = req_wdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= 32'h0000_0000;
            end else if (do_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                    end
                end
            end
        end
    end

    assign load_word = mem[word_idx];

    mem_lane_align u_align (
        .word     (load_word),
        .lane     (lane),
        .size     (req_size),
        .zero_ext (req_unsigned),
        .rdata    (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'h0000_0000;
        end else begin
            resp_valid <= accept;
            resp_error <= accept & req_err;
            resp_rdata <= (accept && !req_write && !req_err) ? load_data : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: one zero-filling instance and one that keeps
// contents across reset, both with a 16-word array.
module tb_data_ram;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        a_reset, a_valid, a_ready, a_write, a_uns;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_rvalid, a_rerr;

    logic        b_reset, b_valid, b_ready, b_write, b_uns;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_rvalid, b_rerr;

    int vectors = 0;
    int miscompares = 0;
    int n;

    data_ram #(.ADDR_WIDTH(32), .DEPTH_WORDS(16), .INIT_CLEAR(1)) dut_a (
        .clock(clock), .reset(a_reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_size(a_size), .req_unsigned(a_uns), .req_address(a_addr),
        .req_wdata(a_wdata), .resp_valid(a_rvalid), .resp_rdata(a_rdata),
        .resp_error(a_rerr)
    );

    data_ram #(.ADDR_WIDTH(32), .DEPTH_WORDS(16), .INIT_CLEAR(0)) dut_b (
        .clock(clock), .reset(b_reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_size(b_size), .req_unsigned(b_uns), .req_address(b_addr),
        .req_wdata(b_wdata), .resp_valid(b_rvalid), .resp_rdata(b_rdata),
        .resp_error(b_rerr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on instance A (sel=0) or B (sel=1); checks the response next cycle.
    task automatic req(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input bit exp_e, input string tag);
        if (!sel) begin
            a_valid = 1'b1; a_write = wr; a_size = sz; a_uns = uns; a_addr = addr; a_wdata = wd;
        end else begin
            b_valid = 1'b1; b_write = wr; b_size = sz; b_uns = uns; b_addr = addr; b_wdata = wd;
        end
        @(posedge clock);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk({tag, "_valid"}, sel ? 32'(b_rvalid) : 32'(a_rvalid), 32'd1);
        chk({tag, "_rdata"}, sel ? b_rdata : a_rdata, exp_d);
        chk({tag, "_error"}, sel ? 32'(b_rerr) : 32'(a_rerr), 32'(exp_e));
    endtask

    task automatic wait_ready_a(input string tag);
        n = 0;
        while (!a_ready && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    initial begin
        a_reset = 1'b1; a_valid = 1'b0; a_write = 1'b0; a_size = 2'd0; a_uns = 1'b0;
        a_addr = '0; a_wdata = '0;
        b_reset = 1'b1; b_valid = 1'b0; b_write = 1'b0; b_size = 2'd0; b_uns = 1'b0;
        b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("a_rst_ready", 32'(a_ready), 32'd0);
        chk("a_rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("a_rst_rdata", a_rdata, 32'd0);
        chk("a_rst_rerr", 32'(a_rerr), 32'd0);
        chk("b_rst_ready", 32'(b_ready), 32'd1);

        // Instance B keeps its contents across reset.
        b_reset = 1'b0;
        req(1, 1, 2'd2, 0, 32'h8, 32'h1234_5678, 32'h0, 0, "b_sw8");
        b_reset = 1'b1;
        @(posedge clock);
        #1;
        chk("b_pulse_ready", 32'(b_ready), 32'd1);
        chk("b_pulse_rvalid", 32'(b_rvalid), 32'd0);
        b_reset = 1'b0;
        req(1, 0, 2'd2, 0, 32'h8, 32'h0, 32'h1234_5678, 0, "b_lw8");

        // Instance A: zero-fill takes exactly 16 cycles.
        a_reset = 1'b0;
        wait_ready_a("a_clear_cycles");
        req(0, 0, 2'd2, 0, 32'h0,  32'h0, 32'h0, 0, "lw_0");
        req(0, 0, 2'd2, 0, 32'h3C, 32'h0, 32'h0, 0, "lw_3c");
        req(0, 1, 2'd2, 0, 32'h4,  32'h8BAD_F00D, 32'h0, 0, "sw_4");
        req(0, 0, 2'd0, 0, 32'h7,  32'h0, 32'hFFFF_FF8B, 0, "lb_7");
        req(0, 0, 2'd0, 1, 32'h7,  32'h0, 32'h0000_008B, 0, "lbu_7");
        req(0, 0, 2'd1, 0, 32'h4,  32'h0, 32'hFFFF_F00D, 0, "lh_4");
        req(0, 0, 2'd1, 1, 32'h6,  32'h0, 32'h0000_8BAD, 0, "lhu_6");
        req(0, 0, 2'd1, 0, 32'h6,  32'h0, 32'hFFFF_8BAD, 0, "lh_6");
        req(0, 1, 2'd0, 0, 32'h5,  32'h0000_005A, 32'h0, 0, "sb_5");
        req(0, 0, 2'd2, 0, 32'h4,  32'h0, 32'h8BAD_5A0D, 0, "lw_4_b2b");
        #4;
        @(posedge clock);
        #1;
        chk("idle_rvalid", 32'(a_rvalid), 32'd0);

        req(0, 0, 2'd2, 0, 32'h6,  32'h0, 32'h0, 1, "err_lw6");
        req(0, 1, 2'd1, 0, 32'h3,  32'hFFFF, 32'h0, 1, "err_sh3");
        req(0, 0, 2'd3, 0, 32'h0,  32'h0, 32'h0, 1, "err_size3");
        req(0, 1, 2'd2, 0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1, "err_sw40");
        req(0, 1, 2'd2, 0, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 1, "err_swhigh");
        req(0, 0, 2'd2, 0, 32'h4,  32'h0, 32'h8BAD_5A0D, 0, "lw_4_after_err");
        req(0, 0, 2'd2, 0, 32'h0,  32'h0, 32'h0, 0, "lw_0_no_alias");

        // Reset one cycle after an accepted load, with another load still presented.
        a_valid = 1'b1; a_write = 1'b0; a_size = 2'd2; a_addr = 32'h4;
        @(posedge clock);
        #1;
        chk("pre_rst_rvalid", 32'(a_rvalid), 32'd1);
        a_reset = 1'b1;
        @(posedge clock);
        #1;
        a_valid = 1'b0;
        chk("rst_drop_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_drop_ready", 32'(a_ready), 32'd0);
        a_reset = 1'b0;

        // Reset again part-way through the clear.
        repeat (5) @(posedge clock);
        #1;
        chk("midclear_ready", 32'(a_ready), 32'd0);
        a_reset = 1'b1;
        @(posedge clock);
        #1;
        a_reset = 1'b0;
        wait_ready_a("a_reclear_cycles");
        req(0, 0, 2'd2, 0, 32'h4, 32'h0, 32'h0, 0, "lw_4_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Parametrised byte-addressable, little-endian data memory for the MIPS datapath; successor to the fixed 16-byte word RAM.
- Adds MIPS load/store sizes (byte/half/word) with byte enables and signed/unsigned load extension.
- Adds a valid/ready request channel, a registered response with an error flag, and an optional zero-fill of the array after reset.
- Sits between the core's MEM stage and the data array.

Parameters:
- ADDR_WIDTH, 32, width of the request byte address.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- INIT_CLEAR, 1, 1 = zero-fill the array after reset; 0 = contents kept across reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_address  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse; response for the request accepted in the previous cycle.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  request was rejected (see error rules).

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; it is sampled on the rising edge of clock.
- Storage: DEPTH_WORDS x 32 array, little-endian. Byte at address A is word A>>2, lane A[1:0]; lane 0 = bits [7:0].
- Accept rule: a request is accepted when req_valid && req_ready at a rising edge. Requests in a cycle with reset high are ignored and perform no write.
- Error rules:
  - Error if req_size==3.
  - Error if half with address[0]=1.
  - Error if word with address[1:0]!=0.
  - Error if (address>>2) >= DEPTH_WORDS.
  - An errored request performs no write.
- Store: byte enables come from size and lane; data is replicated into the selected lanes. The write happens on the accept edge. Response next cycle: resp_valid=1, resp_error=0, resp_rdata=0.
- Load: the word is read on the accept edge. Lane select and extension are applied when the response register is loaded. Response next cycle with resp_rdata valid.
- Latency: exactly 1 cycle, request accept to resp_valid, for every request.
- Throughput: one request per cycle; no backpressure on responses.
- Back-to-back accesses: a load accepted the cycle after a store to the same word returns the newly written data.
- FSM states:
  - CLEAR: req_ready=0; a counter walks word 0..DEPTH_WORDS-1, writing 0, one word per cycle.
  - READY: req_ready=1.
- FSM transitions:
  - reset -> CLEAR with counter=0 if INIT_CLEAR=1, else reset -> READY.
  - CLEAR -> READY after writing word DEPTH_WORDS-1, so req_ready rises exactly DEPTH_WORDS cycles after reset deasserts.
  - Reset during CLEAR restarts the counter at 0.
- Reset values:
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - req_ready=0 if INIT_CLEAR=1, else 1 (first cycle after reset).
- Reset mid-operation: a response due in the cycle after a reset edge is dropped (resp_valid=0).
- Widths: the word index uses log2(DEPTH_WORDS) bits. Range check compares the full address against the depth; there is no wrap-around or aliasing.

Decomposition:
- Package mem_pkg:
  - mem_size_t enum: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
  - ram_state_t enum: CLEAR, READY.
  - Function computing byte enables from size and address[1:0].
- Sub-module mem_lane_align (combinational): takes the 32-bit word, address[1:0], size and unsigned flag; produces the extended load value.
- Store byte-enable and data replication stay in data_ram via the package function.

Test Plan:
- Reset clear, DEPTH_WORDS=16, INIT_CLEAR=1: deassert reset -> req_ready low 16 cycles, then high; lw at 0x0 and 0x3C -> 0x00000000, resp_error=0.
- Loads after sw 0x8BADF00D @0x4:
  - lb @0x7 -> 0xFFFFFF8B; lbu @0x7 -> 0x0000008B.
  - lh @0x4 -> 0xFFFFF00D; lhu @0x6 -> 0x00008BAD.
- Back-to-back: sb 0x5A @0x5 followed next cycle by lw @0x4 -> 0x8BAD5A0D; store response has rdata=0.
- Errors:
  - lw @0x6, sh @0x3 and size=3 -> resp_error=1, rdata=0.
  - sw @0x40 with DEPTH_WORDS=16 -> resp_error=1.
  - Follow-up lw @0x4 unchanged.
- Reset mid-clear after 5 cycles -> req_ready stays low a full 16 cycles from the new deassert. Reset one cycle after accepting a load -> no resp_valid.
- INIT_CLEAR=0: sw 0x12345678 @0x8, pulse reset -> req_ready=1 the first cycle after reset; lw @0x8 -> 0x12345678.
